// File: rtl/uart_rx_dec_pkg.sv
// Shared constants for the UART decimal-number receiver: ASCII codes, parser and
// byte-receiver state encodings, and small character helpers.
package uart_rx_dec_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;

  localparam logic [2:0] MAX_DIGITS = 3'd5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_SKIP  = 2'd2;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  function automatic logic [16:0] digit_val(input logic [7:0] b);
    logic [7:0] d;
    d = b - ASCII_0;
    return {9'd0, d};
  endfunction

endpackage

// File: rtl/uart_rx_dec_rx.sv
// 8N1 byte receiver working on an already-synchronized serial line.
// Bit timing uses a down-counter reloaded at every sample point.
//
// state    | meaning
// RX_IDLE  | waiting for a 1->0 edge on the line
// RX_START | counting to the start-bit centre for the recheck
// RX_DATA  | sampling 8 data bits, LSB first
// RX_STOP  | sampling the stop bit, then reporting done or frame error
module uart_rx
  import uart_rx_dec_pkg::*;
#(
  parameter int BAUD_CNT = 434
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rxd_sync,
  output logic [7:0] rx_byte,
  output logic       rx_done,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(BAUD_CNT + 1);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(BAUD_CNT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(BAUD_CNT - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_byte;
  logic             r_rxd_d;
  logic             r_done;
  logic             r_ferr;
  logic             w_tc;

  assign w_tc      = (r_cnt == '0);
  assign rx_byte   = r_byte;
  assign rx_done   = r_done;
  assign frame_err = r_ferr;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_byte    <= '0;
      r_rxd_d   <= 1'b1;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_rxd_d <= rxd_sync;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (r_rxd_d && !rxd_sync) begin
            r_state <= RX_START;
            r_cnt   <= HALF_LD;
          end
        end
        RX_START: begin
          if (w_tc) begin
            // A high line at mid-start is a glitch, not a frame.
            if (rxd_sync) begin
              r_state <= RX_IDLE;
            end else begin
              r_state   <= RX_DATA;
              r_cnt     <= FULL_LD;
              r_bit_idx <= '0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (w_tc) begin
            r_shift   <= {rxd_sync, r_shift[7:1]};
            r_cnt     <= FULL_LD;
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) begin
              r_state <= RX_STOP;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (w_tc) begin
            r_state <= RX_IDLE;
            if (rxd_sync) begin
              r_done <= 1'b1;
              r_byte <= r_shift;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_dec.sv
// Receives ASCII decimal numbers over UART and reports each CR-terminated value
// in the 0..65535 range; malformed lines are flagged and skipped up to the next CR.
//
// state    | meaning
// ST_IDLE  | between numbers, waiting for the first digit
// ST_ACCUM | accumulating digits of a number
// ST_SKIP  | discarding a bad line until CR
module uart_rx_dec
  import uart_rx_dec_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        uart_rxd,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        data_err
);

  localparam int BAUD_CNT = CLK_FREQ / BAUD_RATE;

  logic        r_sync1;
  logic        r_sync2;
  logic [1:0]  r_state;
  logic [16:0] r_acc;
  logic [2:0]  r_cnt;

  logic [7:0]  w_rx_byte;
  logic        w_rx_done;
  logic        w_frame_err;
  logic        w_digit;
  logic [16:0] w_dval;
  logic [16:0] w_acc_next;
  logic        w_too_long;
  logic        w_overflow;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
    end
  end

  uart_rx #(
    .BAUD_CNT(BAUD_CNT)
  ) u_rx (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .rxd_sync (r_sync2),
    .rx_byte  (w_rx_byte),
    .rx_done  (w_rx_done),
    .frame_err(w_frame_err)
  );

  // The digit-count check guards the product: with at most 4 digits held,
  // acc*10+9 stays below 2^17.
  assign w_digit    = is_digit(w_rx_byte);
  assign w_dval     = digit_val(w_rx_byte);
  assign w_acc_next = r_acc * 17'd10 + w_dval;
  assign w_too_long = (r_cnt >= MAX_DIGITS);
  assign w_overflow = (w_acc_next > 17'd65535);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      data_err   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      data_err   <= 1'b0;
      if (w_frame_err) begin
        data_err <= 1'b1;
        r_state  <= ST_SKIP;
      end else if (w_rx_done) begin
        case (r_state)
          ST_IDLE: begin
            if (w_digit) begin
              r_acc   <= w_dval;
              r_cnt   <= 3'd1;
              r_state <= ST_ACCUM;
            end else if (w_rx_byte != ASCII_CR && w_rx_byte != ASCII_LF) begin
              data_err <= 1'b1;
              r_state  <= ST_SKIP;
            end
          end
          ST_ACCUM: begin
            if (w_digit) begin
              if (w_too_long || w_overflow) begin
                data_err <= 1'b1;
                r_state  <= ST_SKIP;
              end else begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 1'b1;
              end
            end else if (w_rx_byte == ASCII_CR) begin
              data       <= r_acc[15:0];
              data_valid <= 1'b1;
              r_state    <= ST_IDLE;
            end else if (w_rx_byte != ASCII_LF) begin
              data_err <= 1'b1;
              r_state  <= ST_SKIP;
            end
          end
          ST_SKIP: begin
            if (w_rx_byte == ASCII_CR) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_dec.sv
// Directed bench for uart_rx_dec: expected pulses are queued as lines are sent and
// matched in order as data_valid/data_err appear.
module tb_uart_rx_dec;

  // 16 clocks per bit keeps the run short while still exercising 115200 baud.
  localparam int CLK_FREQ  = 1_843_200;
  localparam int BAUD_RATE = 115200;
  localparam int BIT_CYC   = CLK_FREQ / BAUD_RATE;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        uart_rxd = 1'b1;
  logic [15:0] data;
  logic        data_valid;
  logic        data_err;

  typedef struct {
    logic        is_err;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 sys_clk = ~sys_clk;

  uart_rx_dec #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .uart_rxd  (uart_rxd),
    .data      (data),
    .data_valid(data_valid),
    .data_err  (data_err)
  );

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // rst_at_bit >= 0 asserts reset mid-way through that frame bit and abandons the frame.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1,
                           input int rst_at_bit = -1);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = frame[i];
      if (i == rst_at_bit) begin
        wait_cyc(BIT_CYC / 2);
        sys_rst = 1'b1;
        wait_cyc(4);
        sys_rst  = 1'b0;
        uart_rxd = 1'b1;
        wait_cyc(2 * BIT_CYC);
        return;
      end
      wait_cyc(BIT_CYC);
    end
    uart_rxd = 1'b1;
    wait_cyc(2 * BIT_CYC);
  endtask

  // '|' stands for CR and '^' for LF in line strings.
  task automatic send_line(input string s);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == "|") c = 8'h0D;
      else if (c == "^") c = 8'h0A;
      send_byte(c);
    end
  endtask

  task automatic expect_valid(input logic [15:0] v);
    exp_t e;
    e.is_err = 1'b0;
    e.val    = v;
    exp_q.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.val    = '0;
    exp_q.push_back(e);
  endtask

  task automatic check_drained(input string tag);
    wait_cyc(3 * BIT_CYC);
    checks++;
    assert (exp_q.size() === 0) else begin
      failures++;
      $error("FAIL %s missing_pulses observed=%0d expected=0", tag, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_data(input string tag, input logic [15:0] v);
    checks++;
    assert (data === v) else begin
      failures++;
      $error("FAIL %s data observed=%0d expected=%0d", tag, data, v);
    end
  endtask

  task automatic check_quiet(input string tag);
    checks++;
    assert ({data_valid, data_err} === 2'b00) else begin
      failures++;
      $error("FAIL %s pulses observed=%b expected=00", tag, {data_valid, data_err});
    end
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (!sys_rst && (data_valid || data_err)) begin
      checks++;
      assert (!(data_valid && data_err)) else begin
        failures++;
        $error("FAIL both_pulses observed=11 expected=not_both");
      end
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_pulse observed valid=%0b err=%0b data=%0d expected=none",
               data_valid, data_err, data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (data_err === e.is_err) else begin
          failures++;
          $error("FAIL pulse_kind observed err=%0b expected err=%0b", data_err, e.is_err);
        end
        if (!e.is_err) begin
          checks++;
          assert (data === e.val) else begin
            failures++;
            $error("FAIL valid_data observed=%0d expected=%0d", data, e.val);
          end
        end
      end
    end
  end

  initial begin
    wait_cyc(5);
    check_data("reset", 16'd0);
    check_quiet("reset");
    sys_rst = 1'b0;
    wait_cyc(2 * BIT_CYC);

    expect_valid(16'd12345);
    send_line("12345|");
    check_drained("basic");
    check_data("basic_hold", 16'd12345);

    expect_valid(16'd65535);
    send_line("65535|^");
    expect_err();
    send_line("65536|");
    check_drained("range");
    check_data("range_hold", 16'd65535);

    send_line("|");
    check_drained("bare_cr");
    expect_valid(16'd0);
    send_line("0|");
    check_drained("zero");

    expect_err();
    expect_valid(16'd7);
    send_line("12a4|7|");
    check_drained("bad_char");

    expect_err();
    send_byte("5", 1'b0);
    expect_valid(16'd9);
    send_line("|9|");
    check_drained("frame_err");
    check_data("frame_err_hold", 16'd9);

    send_byte("3");
    send_byte("3", 1'b1, 5);
    check_data("mid_reset", 16'd0);
    check_quiet("mid_reset");
    expect_valid(16'd21);
    send_line("21|");
    check_drained("after_reset");
    check_data("after_reset_hold", 16'd21);

    expect_valid(16'd42);
    send_line("00042|");
    expect_err();
    send_line("000042|");
    check_drained("digit_limit");
    check_data("digit_limit_hold", 16'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx_dec.md
UART_RX_DEC -- requirements
Module: uart_rx_dec

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate in bit/s.
REQ-003 SHALL have port sys_clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port uart_rxd  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port data  output  16  last successfully parsed decimal value.
REQ-007 SHALL have port data_valid  output  1  one-cycle pulse; data updated on the same cycle.
REQ-008 SHALL have port data_err  output  1  one-cycle pulse on any frame, character or range error.

Function
REQ-009 SHALL pass uart_rxd through a 2-FF synchronizer before any use, so input latency is 2 cycles.
REQ-010 SHALL use frame format 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-011 SHALL use bit period BAUD_CNT = CLK_FREQ/BAUD_RATE cycles (integer division), which is 434 at the defaults.
REQ-012 SHALL start a frame on a synchronized 1->0 edge while the byte receiver is idle.
REQ-013 SHALL recheck the start bit at BAUD_CNT/2; if the line is high there, it SHALL silently abort the frame and return to idle.
REQ-014 SHALL sample each data bit and the stop bit at the bit centre, BAUD_CNT after the previous sample.
REQ-015 SHALL pulse rx_done for 1 cycle at the stop-bit sample with rx_byte valid, and SHALL raise frame_err instead if the stop bit is 0.
REQ-016 SHALL run the parser FSM with states IDLE, ACCUM and SKIP.
REQ-017 In IDLE, a digit byte (0x30-0x39) SHALL load acc = digit, set cnt = 1 and move to ACCUM; CR (0x0D) and LF (0x0A) SHALL be ignored; any other byte SHALL pulse data_err and move to SKIP.
REQ-018 In ACCUM, a digit SHALL update acc = acc*10 + digit using 17-bit arithmetic and increment cnt.
REQ-019 In ACCUM, if the result exceeds 65535 or cnt would exceed 5, the FSM SHALL pulse data_err and move to SKIP.
REQ-020 In ACCUM, a CR byte SHALL set data = acc[15:0], pulse data_valid and return to IDLE.
REQ-021 In ACCUM, an LF byte SHALL be ignored; any other byte SHALL pulse data_err and move to SKIP.
REQ-022 In SKIP, every byte except CR SHALL be discarded without a further data_err; CR SHALL return the FSM to IDLE without data_valid.
REQ-023 On frame_err in any state, the FSM SHALL pulse data_err, discard the byte, and move to SKIP.
REQ-024 data_valid and data_err SHALL assert exactly 1 cycle after the corresponding rx_done pulse, and SHALL never assert together.
REQ-025 Leading zeros SHALL count toward the 5-digit limit ("00042" is accepted, "000042" is an error).
REQ-026 data SHALL hold its value between data_valid pulses.

Reset
REQ-027 While sys_rst=1, synchronizer flops SHALL be 1, the FSM SHALL be IDLE, acc=0, cnt=0, data=0, data_valid=0, data_err=0, and the byte receiver SHALL be idle with its counters cleared.
REQ-028 Reset asserted mid-frame SHALL abandon the partial byte and partial number; after release, reception SHALL resume only on a new start edge.

Structure
REQ-029 Shared package SHALL hold the ASCII constants (CR 0x0D, LF 0x0A, digit 0x30-0x39), the parser state encodings, and the value 5 for maximum digit count.
REQ-030 The byte-level receiver SHALL be the sub-module uart_rx, with ports sys_clk, sys_rst, rxd_sync, rx_byte[7:0], rx_done, frame_err; uart_rx_dec SHALL contain the synchronizer and parser FSM.

Verification
REQ-031 Sending "12345\r" at 115200 -> one data_valid pulse with data=12345, and data_err stays 0.
REQ-032 Sending "65535\r\n" -> data=65535 valid; then "65536\r" -> data_err pulse at the final '6', no data_valid, and data stays 65535.
REQ-033 Sending "\r", then "0\r" -> no pulse for the bare CR, then data_valid with data=0.
REQ-034 Sending "12a4\r7\r" -> data_err pulse at 'a', no valid for that line, then data_valid with data=7.
REQ-035 Sending byte '5' with stop bit forced to 0, then "\r9\r" -> data_err pulse, CR ends SKIP, then data_valid with data=9.
REQ-036 Asserting sys_rst during bit 4 of '3' in "33\r", releasing it, then sending "21\r" -> data_valid only for 21, and data=21.
